// File: rtl/cpu_debug_console.sv
// Board front end for the single-cycle CPU: a debounced push-button drives the CPU step clock,
// and a switch-selected pair of debug bytes is scanned onto a 4-digit common-anode display.
module cpu_debug_console #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_DIV        = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_btn,
  input  logic [1:0]  sel,
  input  logic [31:0] PC,
  input  logic [31:0] NPC,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [31:0] reg_out_rs,
  input  logic [31:0] reg_out_rt,
  input  logic [31:0] alu_out,
  input  logic [31:0] db,
  output logic        cpu_clk,
  output logic [15:0] step_count,
  output logic [3:0]  an,
  output logic [7:0]  seg
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef struct packed {
    logic [7:0] left;
    logic [7:0] right;
  } page_t;

  logic          s1, s2;
  logic [DW-1:0] db_cnt;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  page_t         page;
  logic [3:0]    nib;

  // Only the low byte of each debug bus is ever displayed.
  logic unused_bits;
  assign unused_bits = ^{PC[31:8], NPC[31:8], reg_out_rs[31:8], reg_out_rt[31:8],
                         alu_out[31:8], db[31:8]};

  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  4'hF: hex7 = 8'h8E;
    endcase
  endfunction

  // cpu_clk is the accepted level; the counter only runs while the synced input disagrees with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      db_cnt     <= '0;
      cpu_clk    <= 1'b0;
      step_count <= '0;
    end else begin
      s1 <= step_btn;
      s2 <= s1;
      if (s2 == cpu_clk) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt  <= '0;
        cpu_clk <= s2;
        if (s2) step_count <= step_count + 16'd1;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  always_comb begin
    page = '0;
    case (sel)
      2'b00: page = '{left: PC[7:0],        right: NPC[7:0]};
      2'b01: page = '{left: {3'b000, rs},   right: reg_out_rs[7:0]};
      2'b10: page = '{left: {3'b000, rt},   right: reg_out_rt[7:0]};
      2'b11: page = '{left: alu_out[7:0],   right: db[7:0]};
    endcase
  end

  always_comb begin
    nib = page.right[3:0];
    case (idx)
      2'd0: nib = page.right[3:0];
      2'd1: nib = page.right[7:4];
      2'd2: nib = page.left[3:0];
      2'd3: nib = page.left[7:4];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      an       <= 4'b1111;
      seg      <= 8'hFF;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      // Pins follow the pre-advance index, so they lag the index by one cycle.
      an  <= ~(4'b0001 << idx);
      seg <= hex7(nib);
    end
  end
endmodule

// File: tb/tb_cpu_debug_console.sv
// Scoreboard bench: stimulus pushes expected cpu_clk edges and display frames into queues,
// monitors pop and compare whenever the DUT changes cpu_clk or its digit enables.
module tb_cpu_debug_console;
  localparam int DB = 4;
  localparam int SD = 3;
  localparam int LAT = 2 + DB;  // two sync flops, then the debounce hold

  logic        clk = 1'b0, reset = 1'b1, step_btn = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [31:0] PC = '0, NPC = '0, reg_out_rs = '0, reg_out_rt = '0, alu_out = '0, db = '0;
  logic [4:0]  rs = '0, rt = '0;
  logic        cpu_clk;
  logic [15:0] step_count;
  logic [3:0]  an;
  logic [7:0]  seg;

  cpu_debug_console #(.DEBOUNCE_CYCLES(DB), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .step_btn(step_btn), .sel(sel),
    .PC(PC), .NPC(NPC), .rs(rs), .rt(rt), .reg_out_rs(reg_out_rs), .reg_out_rt(reg_out_rt),
    .alu_out(alu_out), .db(db), .cpu_clk(cpu_clk), .step_count(step_count), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct { logic lvl; logic [15:0] cnt; int at; } ev_t;
  typedef struct { logic [3:0] an; logic [7:0] seg; } dsp_t;
  ev_t  ev_q[$];
  dsp_t dsp_q[$];
  ev_t  ev;
  dsp_t dsp;

  int total = 0, bad = 0, cyc = 0, last_dsp = 0;
  logic [15:0] exp_cnt = '0;
  logic disp_on = 1'b0, prev_clk = 1'b0;
  logic [3:0] prev_an = 4'b1111;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // cpu_clk / step_count monitor
  always @(negedge clk) begin
    if (cpu_clk !== prev_clk) begin
      if (ev_q.size() == 0) begin
        total++; bad++;
        $display("FAIL cpu_clk_unexpected: got %0b want %0b (cycle %0d)", cpu_clk, prev_clk, cyc);
      end else begin
        ev = ev_q.pop_front();
        check("cpu_clk_level", {31'b0, cpu_clk}, {31'b0, ev.lvl});
        check("step_count", {16'b0, step_count}, {16'b0, ev.cnt});
        check("cpu_clk_cycle", cyc, ev.at);
      end
    end
    prev_clk = cpu_clk;
  end

  // display monitor
  always @(negedge clk) begin
    if (disp_on && an !== prev_an) begin
      if (dsp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL an_unexpected: got %b want %b (cycle %0d)", an, prev_an, cyc);
      end else begin
        dsp = dsp_q.pop_front();
        check("an", {28'b0, an}, {28'b0, dsp.an});
        check("seg", {24'b0, seg}, {24'b0, dsp.seg});
        check("digit_hold", cyc - last_dsp, SD);
        last_dsp = cyc;
      end
    end
    prev_an = an;
  end

  task automatic press(input int hi, input int lo, input bit acc);
    @(negedge clk);
    step_btn = 1'b1;
    if (acc) begin
      exp_cnt = exp_cnt + 16'd1;
      ev_q.push_back('{1'b1, exp_cnt, cyc + LAT});
    end
    repeat (hi) @(negedge clk);
    step_btn = 1'b0;
    if (acc) ev_q.push_back('{1'b0, exp_cnt, cyc + LAT});
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] v);
    int n = 0;
    while (an !== v && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (an !== v) begin
      total++; bad++;
      $display("FAIL wait_an: got %b want %b", an, v);
    end
  endtask

  // Show one page and expect digits 0..3 in scan order.
  task automatic show(input logic [1:0] s, input logic [7:0] l, input logic [7:0] r,
                      input logic [7:0] d3, input logic [7:0] d2,
                      input logic [7:0] d1, input logic [7:0] d0);
    @(negedge clk);
    sel = s;
    case (s)
      2'b00: begin PC = {24'hA5A5A5, l}; NPC = {24'h5A5A5A, r}; end
      2'b01: begin rs = l[4:0]; reg_out_rs = {24'hFFFFFF, r}; end
      2'b10: begin rt = l[4:0]; reg_out_rt = {24'h123456, r}; end
      2'b11: begin alu_out = {24'hDEADBE, l}; db = {24'h0F0F0F, r}; end
    endcase
    wait_an(4'b1011);
    wait_an(4'b0111);
    #1;
    dsp_q.push_back('{4'b1110, d0});
    dsp_q.push_back('{4'b1101, d1});
    dsp_q.push_back('{4'b1011, d2});
    dsp_q.push_back('{4'b0111, d3});
    last_dsp = cyc;
    disp_on = 1'b1;
    repeat (13) @(negedge clk);
    #1 disp_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_an", {28'b0, an}, 32'hF);
    check("rst_seg", {24'b0, seg}, 32'hFF);
    check("rst_cpu_clk", {31'b0, cpu_clk}, 32'h0);
    check("rst_step_count", {16'b0, step_count}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("first_an", {28'b0, an}, 32'hE);
    check("first_seg", {24'b0, seg}, 32'hC0);

    press(3, 8, 0);     // glitch shorter than the hold
    press(10, 10, 1);
    press(4, 8, 1);     // minimum accepted hold
    check("count_after_presses", {16'b0, step_count}, 32'h2);

    // Preload near the wrap point instead of issuing 65534 presses.
    @(negedge clk);
    force dut.step_count = 16'hFFFE;
    #1 release dut.step_count;
    exp_cnt = 16'hFFFE;
    press(5, 8, 1);
    press(5, 8, 1);
    check("wrapped_count", {16'b0, step_count}, 32'h0);

    // Reset mid-debounce with s2 already high.
    @(negedge clk);
    step_btn = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_cpu_clk", {31'b0, cpu_clk}, 32'h0);
    check("midrst_count", {16'b0, step_count}, 32'h0);
    check("midrst_an", {28'b0, an}, 32'hF);
    check("midrst_seg", {24'b0, seg}, 32'hFF);
    exp_cnt = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_cnt = 16'd1;
    ev_q.push_back('{1'b1, exp_cnt, cyc + LAT});
    repeat (8) @(negedge clk);
    step_btn = 1'b0;
    ev_q.push_back('{1'b0, exp_cnt, cyc + LAT});
    repeat (8) @(negedge clk);

    show(2'b00, 8'h48, 8'h4C, 8'h99, 8'h80, 8'h99, 8'hC6);
    show(2'b01, 8'h1F, 8'hA5, 8'hF9, 8'h8E, 8'h88, 8'h92);
    show(2'b10, 8'h0A, 8'h3B, 8'hC0, 8'h88, 8'hB0, 8'h83);
    show(2'b11, 8'hD2, 8'hE7, 8'hA1, 8'hA4, 8'h86, 8'hF8);
    show(2'b00, 8'h96, 8'h69, 8'h90, 8'h82, 8'h82, 8'h90);

    repeat (4) @(negedge clk);
    check("ev_q_drained", ev_q.size(), 0);
    check("dsp_q_drained", dsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
